vga_sync_receiver: RTL and testbench

Receive-side counterpart of the sync-pulse/test-pattern transmit chain: consumes HSync/VSync plus RGB video and regenerates column/row counts aligned to the incoming syncs. Measures every line and frame against the expected timing parameters and asserts a lock flag after consecutive conforming frames. Produces a per-frame checksum of active video so test patterns can be checked on-chip or in simulation.

---
 rtl/vga_sync_receiver.sv | 116 +++++++++++
 tb/tb_vga_sync_receiver.sv | 127 ++++++++++++
 2 files changed

// File: rtl/vga_sync_receiver.sv
// vga_sync_receiver: regenerates col/row counts from HSync/VSync, checks timing, locks and checksums frames
module vga_sync_receiver #(
  parameter int VIDEO_WIDTH = 3,
  parameter int TOTAL_COLS  = 800,
  parameter int TOTAL_ROWS  = 525,
  parameter int ACTIVE_COLS = 640,
  parameter int ACTIVE_ROWS = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int COUNT_WIDTH = 10
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_HSync,
  input  logic                   i_VSync,
  input  logic [VIDEO_WIDTH-1:0] i_Red_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Grn_Video,
  input  logic [VIDEO_WIDTH-1:0] i_Blu_Video,
  output logic [COUNT_WIDTH-1:0] o_Col_Count,
  output logic [COUNT_WIDTH-1:0] o_Row_Count,
  output logic                   o_Active_Video,
  output logic [VIDEO_WIDTH-1:0] o_Red_Video,
  output logic [VIDEO_WIDTH-1:0] o_Grn_Video,
  output logic [VIDEO_WIDTH-1:0] o_Blu_Video,
  output logic                   o_Locked,
  output logic                   o_Frame_Valid,
  output logic [15:0]            o_Frame_Checksum,
  output logic                   o_Frame_Error
);
  localparam int CW = COUNT_WIDTH;
  localparam int MAXC = 2**CW - 1;
  localparam int OVR = (2*TOTAL_COLS > MAXC) ? MAXC : 2*TOTAL_COLS;
  localparam logic [CW-1:0] C_MAX = '1;
  localparam logic [CW-1:0] ONE = CW'(1);
  localparam logic [CW-1:0] OVR_M1 = CW'(OVR-1);
  localparam logic [CW-1:0] TC_M1 = CW'(TOTAL_COLS-1);
  localparam logic [CW-1:0] TR_M1 = CW'(TOTAL_ROWS-1);
  localparam logic [CW-1:0] AC = CW'(ACTIVE_COLS);
  localparam logic [CW-1:0] AR = CW'(ACTIVE_ROWS);
  localparam logic [3:0] LF = 4'(LOCK_FRAMES);
  logic hs_prev, vs_prev, seen_ls, seen_fs, frame_bad;
  logic [CW-1:0] act_col, act_row;
  logic [3:0] good_cnt;
  logic [15:0] acc;
  logic ls, fs, line_ok, frame_ok, overrun, pix_on;
  logic [15:0] pix_add;
  logic [3:0] good_nxt;
  assign ls = i_HSync & ~hs_prev;
  assign fs = i_VSync & ~vs_prev;
  assign line_ok = ls && o_Col_Count == TC_M1 && act_col == AC;
  assign frame_ok = !frame_bad && line_ok && o_Row_Count == TR_M1 && act_row == AR;
  assign overrun = !ls && o_Col_Count == OVR_M1;
  assign pix_on = i_HSync & i_VSync;
  assign pix_add = pix_on ? 16'(i_Red_Video) + 16'(i_Grn_Video) + 16'(i_Blu_Video) : 16'd0;
  assign good_nxt = (good_cnt == LF) ? LF : good_cnt + 4'd1;
  // position counters, edge history and one-clock video pipeline
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      hs_prev <= 1'b0;
      vs_prev <= 1'b0;
      seen_ls <= 1'b0;
      o_Col_Count <= '0;
      o_Row_Count <= '0;
      act_col <= '0;
      act_row <= '0;
      o_Active_Video <= 1'b0;
      o_Red_Video <= '0;
      o_Grn_Video <= '0;
      o_Blu_Video <= '0;
    end else begin
      hs_prev <= i_HSync;
      vs_prev <= i_VSync;
      seen_ls <= seen_ls | ls;
      o_Col_Count <= ls ? '0 : (o_Col_Count == C_MAX ? o_Col_Count : o_Col_Count + ONE);
      o_Row_Count <= fs ? '0 : (ls && o_Row_Count != C_MAX ? o_Row_Count + ONE : o_Row_Count);
      act_col <= ls ? CW'(i_HSync) : (i_HSync ? act_col + ONE : act_col);
      act_row <= fs ? ONE : (ls && i_VSync ? act_row + ONE : act_row);
      o_Active_Video <= pix_on;
      o_Red_Video <= i_Red_Video;
      o_Grn_Video <= i_Grn_Video;
      o_Blu_Video <= i_Blu_Video;
    end
  end
  // line/frame checks, lock tracking and per-frame checksum
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      seen_fs <= 1'b0;
      frame_bad <= 1'b0;
      good_cnt <= '0;
      acc <= '0;
      o_Locked <= 1'b0;
      o_Frame_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
      o_Frame_Checksum <= '0;
    end else begin
      o_Frame_Valid <= 1'b0;
      o_Frame_Error <= 1'b0;
      acc <= (fs ? 16'd0 : acc) + pix_add;
      if (ls && !fs && seen_ls && !line_ok) frame_bad <= 1'b1;
      if (fs) begin
        seen_fs <= 1'b1;
        frame_bad <= 1'b0;
        if (seen_fs) begin
          o_Frame_Checksum <= acc;
          o_Frame_Valid <= 1'b1;
          o_Frame_Error <= !frame_ok;
          good_cnt <= frame_ok ? good_nxt : 4'd0;
          o_Locked <= frame_ok && good_nxt == LF;
        end
      end
      if (overrun) begin
        frame_bad <= 1'b1;
        o_Locked <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb_vga_sync_receiver: directed frames with a scoreboard of expected per-frame reports
module tb_vga_sync_receiver;
  logic i_Clk = 1'b0, i_Rst_L = 1'b0, i_HSync = 1'b0, i_VSync = 1'b0;
  logic [2:0] i_Red_Video = '0, i_Grn_Video = '0, i_Blu_Video = '0;
  logic [9:0] o_Col_Count, o_Row_Count;
  logic o_Active_Video, o_Locked, o_Frame_Valid, o_Frame_Error;
  logic [2:0] o_Red_Video, o_Grn_Video, o_Blu_Video;
  logic [15:0] o_Frame_Checksum;
  typedef struct {logic [15:0] sum; logic err; logic lock;} exp_t;
  exp_t q[$];
  int checks = 0, failures = 0, nvalid = 0, snap;
  always #5 i_Clk = ~i_Clk;
  vga_sync_receiver #(
    .VIDEO_WIDTH(3), .TOTAL_COLS(10), .TOTAL_ROWS(6), .ACTIVE_COLS(8),
    .ACTIVE_ROWS(4), .LOCK_FRAMES(2), .COUNT_WIDTH(10)
  ) dut (
    .i_Clk(i_Clk), .i_Rst_L(i_Rst_L), .i_HSync(i_HSync), .i_VSync(i_VSync),
    .i_Red_Video(i_Red_Video), .i_Grn_Video(i_Grn_Video), .i_Blu_Video(i_Blu_Video),
    .o_Col_Count(o_Col_Count), .o_Row_Count(o_Row_Count), .o_Active_Video(o_Active_Video),
    .o_Red_Video(o_Red_Video), .o_Grn_Video(o_Grn_Video), .o_Blu_Video(o_Blu_Video),
    .o_Locked(o_Locked), .o_Frame_Valid(o_Frame_Valid),
    .o_Frame_Checksum(o_Frame_Checksum), .o_Frame_Error(o_Frame_Error)
  );
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  // scoreboard: every frame report is matched against the oldest expectation
  always @(negedge i_Clk) begin
    exp_t e;
    if (o_Frame_Valid === 1'b1) begin
      nvalid++;
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: got valid with checksum %0d expected no report", o_Frame_Checksum);
      end else begin
        e = q.pop_front();
        chk("frame_checksum", o_Frame_Checksum, e.sum);
        chk("frame_error", o_Frame_Error, e.err);
        chk("frame_locked", o_Locked, e.lock);
      end
    end else if (o_Frame_Error === 1'b1) begin
      checks++;
      failures++;
      $display("FAIL error_without_valid: got error=1 expected 0");
    end
  end
  task automatic cyc(bit hs, bit vs, logic [2:0] r, logic [2:0] g, logic [2:0] b);
    i_HSync = hs;
    i_VSync = vs;
    i_Red_Video = r;
    i_Grn_Video = g;
    i_Blu_Video = b;
    @(posedge i_Clk);
    #1;
  endtask
  task automatic frame(int act_rows, logic [2:0] r, logic [2:0] g, logic [2:0] b, int short_row,
                       int long_row, bit chk_cnt, logic [15:0] es, bit ee, bit el);
    int len;
    q.push_back(exp_t'{es, ee, el});
    for (int row = 0; row < 6; row++) begin
      len = (row == short_row) ? 9 : (row == long_row) ? 28 : 10;
      for (int col = 0; col < len; col++) begin
        cyc(col < 8, row < act_rows, r, g, b);
        if (chk_cnt) begin
          chk("col_count", o_Col_Count, col);
          chk("row_count", o_Row_Count, row);
          chk("active_video", o_Active_Video, col < 8 && row < act_rows);
          chk("red_delay", o_Red_Video, r);
          chk("blu_delay", o_Blu_Video, b);
        end
        if (row == long_row && col == 19) chk("locked_before_overrun", o_Locked, 1);
        if (row == long_row && col == 20) chk("locked_at_overrun", o_Locked, 0);
      end
    end
  endtask
  initial begin
    repeat (3) @(posedge i_Clk);
    #1;
    chk("rst_col", o_Col_Count, 0);
    chk("rst_row", o_Row_Count, 0);
    chk("rst_locked", o_Locked, 0);
    chk("rst_valid", o_Frame_Valid, 0);
    chk("rst_checksum", o_Frame_Checksum, 0);
    chk("rst_active", o_Active_Video, 0);
    i_Rst_L = 1'b1;
    frame(4, 1, 2, 3, -1, -1, 1, 192, 0, 0);
    frame(4, 1, 2, 3, -1, -1, 1, 192, 0, 1);
    frame(4, 2, 3, 4, -1, -1, 0, 288, 0, 1);
    frame(4, 1, 2, 3, 2, -1, 0, 192, 1, 0);
    frame(4, 7, 7, 7, -1, -1, 0, 672, 0, 0);
    frame(4, 1, 2, 3, -1, -1, 0, 192, 0, 1);
    frame(3, 1, 2, 3, -1, -1, 0, 144, 1, 0);
    frame(4, 1, 2, 3, -1, -1, 0, 192, 0, 0);
    frame(4, 1, 2, 3, -1, -1, 0, 192, 0, 1);
    frame(4, 1, 2, 3, -1, 1, 0, 192, 1, 0);
    for (int row = 0; row < 2; row++)
      for (int col = 0; col < 10; col++) cyc(col < 8, 1, 1, 2, 3);
    chk("pre_reset_checksum", o_Frame_Checksum, 192);
    i_Rst_L = 1'b0;
    i_HSync = 1'b0;
    i_VSync = 1'b0;
    #1;
    chk("mid_rst_col", o_Col_Count, 0);
    chk("mid_rst_row", o_Row_Count, 0);
    chk("mid_rst_checksum", o_Frame_Checksum, 0);
    chk("mid_rst_active", o_Active_Video, 0);
    chk("mid_rst_red", o_Red_Video, 0);
    chk("mid_rst_locked", o_Locked, 0);
    repeat (2) @(posedge i_Clk);
    #1;
    i_Rst_L = 1'b1;
    snap = nvalid;
    frame(4, 1, 2, 3, -1, -1, 1, 192, 0, 0);
    chk("no_valid_first_fs", nvalid, snap);
    frame(4, 1, 2, 3, -1, -1, 0, 192, 0, 1);
    cyc(1, 1, 1, 2, 3);
    repeat (3) cyc(0, 0, 0, 0, 0);
    chk("queue_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
